axi_config_master: RTL and testbench
====================================

AXI_CONFIG_MASTER -- requirements
Module: axi_config_master

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 6, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI data width (multiple of 8).
REQ-003 SHALL have port M_AXI_ACLK  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port M_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_write  in  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr  in  AXI_ADDR_WIDTH  target byte address.
REQ-009 SHALL have port cmd_wdata  in  AXI_DATA_WIDTH  write data.
REQ-010 SHALL have port cmd_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes.
REQ-011 SHALL have port rsp_valid  out  1  result available.
REQ-012 SHALL have port rsp_ready  in  1  result consumed.
REQ-013 SHALL have port rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes.
REQ-014 SHALL have port rsp_resp  out  2  RRESP or BRESP of the transaction.
REQ-015 SHALL have ports M_AXI_AWVALID out 1, M_AXI_AWREADY in 1, M_AXI_AWADDR out AXI_ADDR_WIDTH, M_AXI_AWPROT out 3: write-address channel.
REQ-016 SHALL have ports M_AXI_WVALID out 1, M_AXI_WREADY in 1, M_AXI_WDATA out AXI_DATA_WIDTH, M_AXI_WSTRB out AXI_DATA_WIDTH/8: write-data channel.
REQ-017 SHALL have ports M_AXI_BVALID in 1, M_AXI_BREADY out 1, M_AXI_BRESP in 2: write-response channel.
REQ-018 SHALL have ports M_AXI_ARVALID out 1, M_AXI_ARREADY in 1, M_AXI_ARADDR out AXI_ADDR_WIDTH, M_AXI_ARPROT out 3: read-address channel.
REQ-019 SHALL have ports M_AXI_RVALID in 1, M_AXI_RREADY out 1, M_AXI_RDATA in AXI_DATA_WIDTH, M_AXI_RRESP in 2: read-data channel.

Function
REQ-020 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP; one transaction outstanding at most.
REQ-021 SHALL assert cmd_ready only in IDLE; handshake latches addr/wdata/wstrb, goes to WR_REQ (cmd_write=1) or RD_REQ (0).
REQ-022 SHALL assert AWVALID and WVALID together on first cycle of WR_REQ; each drops independently on the cycle after its own READY handshake; AW and W handshakes in either order or same cycle are all legal.
REQ-023 SHALL leave WR_REQ for WR_RESP once both AW and W handshakes have completed; BREADY high only in WR_RESP.
REQ-024 SHALL, on BVALID in WR_RESP, capture BRESP, set rsp_rdata=0, go to RESP.
REQ-025 SHALL assert ARVALID in RD_REQ until ARREADY, then go to RD_DATA; RREADY high only in RD_DATA.
REQ-026 SHALL, on RVALID in RD_DATA, capture RDATA/RRESP, go to RESP.
REQ-027 SHALL hold rsp_valid high and rsp_* stable in RESP until rsp_ready, then return to IDLE.
REQ-028 SHALL drive all AXI outputs from registers; VALIDs never drop before their handshake; AWPROT/ARPROT constant 3'b000.
REQ-029 SHALL give minimum latency cmd handshake -> rsp_valid of 3 cycles when slave READYs and response are immediate.
REQ-030 SHALL pass non-OKAY responses through unchanged, no retry.

Reset
REQ-031 SHALL, on ARESETN low, asynchronously enter IDLE with all VALID/READY outputs 0, cmd_ready 0 during reset and 1 from first clock after release, rsp_rdata/rsp_resp/addr/data registers 0.
REQ-032 SHALL abandon any in-flight transaction on reset mid-operation; no response is produced for it.

Structure
REQ-033 SHALL place state encoding and AXI response codes (OKAY 2'b00, SLVERR 2'b10) in shared package axi_config_pkg; no sub-module.

Verification
REQ-034 SHALL test write 0x12345678, addr 0x08, wstrb 0xF against the config-register slave -> rsp_resp 0, slave config_2 = 0x12345678.
REQ-035 SHALL test read-back of addr 0x08 -> rsp_rdata 0x12345678, rsp_resp 0, latency 3 cycles.
REQ-036 SHALL test write with WREADY 4 cycles after AWREADY, and reverse order -> exactly one AW, one W handshake each, BREADY only after both.
REQ-037 SHALL test BRESP=2'b10 with rsp_ready held low 5 cycles -> rsp_valid, rsp_resp=2'b10 stable 5 cycles, cmd_ready low throughout.
REQ-038 SHALL test reset asserted in RD_DATA -> ARVALID/RREADY/rsp_valid 0 immediately, cmd_ready 1 one clock after release.

Source files
------------

// File: rtl/axi_config_pkg.sv
// Shared FSM encoding and AXI constants for the single-outstanding config master.
package axi_config_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] PROT_NONE   = 3'b000;

endpackage

// File: rtl/axi_config_master.sv
// Turns one cmd into one AXI4-Lite read or write; min cmd->rsp latency 3 cycles.
// Stalls on every AXI VALID/READY; holds rsp_* stable until rsp_ready, cmd_ready only when idle.
module axi_config_master
  import axi_config_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 6,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP
);

  state_t                        state, state_nxt;
  logic                          awvalid_q, awvalid_nxt;
  logic                          wvalid_q, wvalid_nxt;
  logic                          arvalid_q, arvalid_nxt;
  logic                          bready_q, bready_nxt;
  logic                          rready_q, rready_nxt;
  logic                          cmd_ready_q, cmd_ready_nxt;
  logic                          rsp_valid_q, rsp_valid_nxt;
  logic [AXI_ADDR_WIDTH-1:0]     addr_q, addr_nxt;
  logic [AXI_DATA_WIDTH-1:0]     wdata_q, wdata_nxt;
  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_nxt;
  logic [AXI_DATA_WIDTH-1:0]     rdata_q, rdata_nxt;
  logic [1:0]                    resp_q, resp_nxt;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state       <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
    end else begin
      state       <= state_nxt;
      awvalid_q   <= awvalid_nxt;
      wvalid_q    <= wvalid_nxt;
      arvalid_q   <= arvalid_nxt;
      bready_q    <= bready_nxt;
      rready_q    <= rready_nxt;
      cmd_ready_q <= cmd_ready_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      wstrb_q     <= wstrb_nxt;
      rdata_q     <= rdata_nxt;
      resp_q      <= resp_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    awvalid_nxt = awvalid_q;
    wvalid_nxt  = wvalid_q;
    arvalid_nxt = arvalid_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    wstrb_nxt   = wstrb_q;
    rdata_nxt   = rdata_q;
    resp_nxt    = resp_q;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_nxt  = cmd_addr;
          wdata_nxt = cmd_wdata;
          wstrb_nxt = cmd_wstrb;
          if (cmd_write) begin
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR_REQ;
          end else begin
            arvalid_nxt = 1'b1;
            state_nxt   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave only once neither is pending.
        if (awvalid_q && M_AXI_AWREADY) awvalid_nxt = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_nxt  = 1'b0;
        if (!awvalid_nxt && !wvalid_nxt) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        if (M_AXI_BVALID && bready_q) begin
          resp_nxt  = M_AXI_BRESP;
          rdata_nxt = '0;
          state_nxt = RESP;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_nxt = 1'b0;
          state_nxt   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID && rready_q) begin
          rdata_nxt = M_AXI_RDATA;
          resp_nxt  = M_AXI_RRESP;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Handshake-side strobes are registered copies of the next state.
    cmd_ready_nxt = (state_nxt == IDLE);
    bready_nxt    = (state_nxt == WR_RESP);
    rready_nxt    = (state_nxt == RD_DATA);
    rsp_valid_nxt = (state_nxt == RESP);
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT_NONE;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT_NONE;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_config_master.sv
// Directed bench for axi_config_master against a small config-register AXI4-Lite slave model.
module tb_axi_config_master;
  import axi_config_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  axi_config_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_expired(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Slave knobs (written by the test) and observations (written by the slave).
  int          aw_lag = 0, w_lag = 0, r_lag = 0;
  logic [1:0]  slv_resp = RESP_OKAY;
  logic [31:0] config_reg [16];
  int          aw_total = 0, w_total = 0, bready_early = 0, vld_drop = 0;

  initial begin : slave
    logic s_rst, s_aw, s_w, s_b, s_ar, s_r;
    logic aw_wait, w_wait, ar_wait, p_aw_wait, p_w_wait, p_ar_wait;
    logic have_aw, have_w, rd_pend;
    logic [AW-1:0] aw_a, ar_a;
    logic [DW-1:0] w_d;
    logic [SW-1:0] w_s;
    int aw_age, w_age, r_wait;
    for (int i = 0; i < 16; i++) config_reg[i] = '0;
    config_reg[4] = 32'hDEADBEEF;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b0; bresp = RESP_OKAY; rvalid = 1'b0; rdata = '0; rresp = RESP_OKAY;
    p_aw_wait = 1'b0; p_w_wait = 1'b0; p_ar_wait = 1'b0;
    have_aw = 1'b0; have_w = 1'b0; rd_pend = 1'b0;
    aw_a = '0; ar_a = '0; w_d = '0; w_s = '0;
    aw_age = 0; w_age = 0; r_wait = 0;
    forever begin
      @(negedge clk);
      s_rst = !rst_n;
      s_aw = awvalid && awready;  aw_wait = awvalid && !awready;
      s_w  = wvalid && wready;    w_wait  = wvalid && !wready;
      s_ar = arvalid && arready;  ar_wait = arvalid && !arready;
      s_b  = bvalid && bready;
      s_r  = rvalid && rready;
      if (!s_rst) begin
        if ((p_aw_wait && !awvalid) || (p_w_wait && !wvalid) || (p_ar_wait && !arvalid))
          vld_drop++;
        if (bready && !(have_aw && have_w)) bready_early++;
      end
      p_aw_wait = aw_wait && !s_rst;
      p_w_wait  = w_wait && !s_rst;
      p_ar_wait = ar_wait && !s_rst;
      if (s_aw) aw_a = awaddr;
      if (s_w) begin w_d = wdata; w_s = wstrb; end
      if (s_ar) ar_a = araddr;
      @(posedge clk);
      #1;
      if (s_rst) begin
        bvalid = 1'b0; rvalid = 1'b0; have_aw = 1'b0; have_w = 1'b0; rd_pend = 1'b0;
        aw_age = 0; w_age = 0;
      end else begin
        if (s_b) begin bvalid = 1'b0; have_aw = 1'b0; have_w = 1'b0; end
        if (s_aw) begin have_aw = 1'b1; aw_total++; aw_age = 0; end
        else if (aw_wait) aw_age++;
        if (s_w) begin have_w = 1'b1; w_total++; w_age = 0; end
        else if (w_wait) w_age++;
        if (have_aw && have_w && !bvalid && !s_b) begin
          bvalid = 1'b1;
          bresp  = slv_resp;
          if (slv_resp == RESP_OKAY)
            for (int b = 0; b < SW; b++)
              if (w_s[b]) config_reg[aw_a[5:2]][8*b +: 8] = w_d[8*b +: 8];
        end
        if (s_r) rvalid = 1'b0;
        if (s_ar) begin rd_pend = 1'b1; r_wait = r_lag; end
        if (rd_pend) begin
          if (r_wait == 0) begin
            rvalid = 1'b1; rdata = config_reg[ar_a[5:2]]; rresp = slv_resp; rd_pend = 1'b0;
          end else r_wait--;
        end
      end
      awready = (aw_age >= aw_lag);
      wready  = (w_age >= w_lag);
      arready = 1'b1;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge where rsp_valid is first seen.
  // lat counts rising edges from the cmd handshake edge (inclusive).
  task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, output int lat);
    int guard;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) bound_expired("cmd_handshake");
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (rsp_valid || lat >= 60) break;
      @(posedge clk);
      lat++;
    end
    if (!rsp_valid) bound_expired("rsp_valid_wait");
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    sresp;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
    int            exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin : main
    int lat, aw0, w0, be0, bad, guard;
    vecs[0] = '{1'b1, 6'h08, 32'h12345678, 4'hF, RESP_OKAY,   32'h00000000, RESP_OKAY,   3};
    vecs[1] = '{1'b0, 6'h08, 32'h0,        4'h0, RESP_OKAY,   32'h12345678, RESP_OKAY,   3};
    vecs[2] = '{1'b1, 6'h0C, 32'hAABBCCDD, 4'h5, RESP_OKAY,   32'h00000000, RESP_OKAY,   3};
    vecs[3] = '{1'b0, 6'h0C, 32'h0,        4'h0, RESP_OKAY,   32'h00BB00DD, RESP_OKAY,   3};
    vecs[4] = '{1'b1, 6'h04, 32'hCAFEF00D, 4'hA, RESP_OKAY,   32'h00000000, RESP_OKAY,   3};
    vecs[5] = '{1'b0, 6'h04, 32'h0,        4'h0, RESP_SLVERR, 32'hCA00F000, RESP_SLVERR, 3};
    vecs[6] = '{1'b1, 6'h10, 32'h00000001, 4'hF, RESP_SLVERR, 32'h00000000, RESP_SLVERR, 3};
    vecs[7] = '{1'b0, 6'h10, 32'h0,        4'h0, RESP_OKAY,   32'hDEADBEEF, RESP_OKAY,   3};
    vecs[8] = '{1'b1, 6'h3C, 32'hFFFFFFFF, 4'h1, RESP_OKAY,   32'h00000000, RESP_OKAY,   3};
    vecs[9] = '{1'b0, 6'h3C, 32'h0,        4'h0, RESP_OKAY,   32'h000000FF, RESP_OKAY,   3};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_handshakes", 32'({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_resp", 32'(rsp_resp), 32'h0);
    check("reset_addr", 32'({awaddr, araddr}), 32'h0);
    rst_n = 1'b1;
    #1 check("cmd_ready_before_first_clk", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    check("cmd_ready_after_release", 32'(cmd_ready), 32'h1);

    for (int i = 0; i < 10; i++) begin
      slv_resp = vecs[i].sresp;
      issue_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat);
      check($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_resp", i), 32'(rsp_resp), 32'(vecs[i].exp_resp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      consume_rsp();
    end
    slv_resp = RESP_OKAY;
    check("slave_config_2", config_reg[2], 32'h12345678);
    check("prot_zero", 32'({awprot, arprot}), 32'h0);

    // W accepted 4 cycles late, then AW accepted 4 cycles late.
    for (int order = 0; order < 2; order++) begin
      aw_lag = (order == 1) ? 4 : 0;
      w_lag  = (order == 1) ? 0 : 4;
      aw0 = aw_total; w0 = w_total; be0 = bready_early;
      issue_cmd(1'b1, 6'h14, 32'h00005A5A + 32'(order), 4'hF, lat);
      check($sformatf("split%0d_latency", order), 32'(lat), 32'd7);
      check($sformatf("split%0d_resp", order), 32'(rsp_resp), 32'h0);
      check($sformatf("split%0d_aw_count", order), 32'(aw_total - aw0), 32'd1);
      check($sformatf("split%0d_w_count", order), 32'(w_total - w0), 32'd1);
      check($sformatf("split%0d_bready_early", order), 32'(bready_early - be0), 32'd0);
      consume_rsp();
      aw_lag = 0; w_lag = 0;
      check($sformatf("split%0d_reg5", order), config_reg[5], 32'h00005A5A + 32'(order));
    end

    // SLVERR response held while rsp_ready stays low.
    slv_resp = RESP_SLVERR;
    issue_cmd(1'b1, 6'h18, 32'h00000011, 4'hF, lat);
    slv_resp = RESP_OKAY;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
      check($sformatf("hold%0d_rsp_resp", i), 32'(rsp_resp), 32'(RESP_SLVERR));
      check($sformatf("hold%0d_cmd_ready", i), 32'(cmd_ready), 32'h0);
      @(negedge clk);
    end
    consume_rsp();

    // Reset while waiting on RVALID.
    r_lag = 20;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h08;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) bound_expired("rst_cmd_handshake");
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rready && guard < 20);
    if (!rready) bound_expired("rst_reach_rd_data");
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({arvalid, rready, rsp_valid}), 32'h0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'h0);
    r_lag = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_cmd_ready_pre_clk", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    check("midrst_cmd_ready_post_clk", 32'(cmd_ready), 32'h1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || rready || arvalid) bad++;
      @(negedge clk);
    end
    check("midrst_no_response", 32'(bad), 32'h0);
    issue_cmd(1'b0, 6'h08, 32'h0, 4'h0, lat);
    check("midrst_recover_rdata", rsp_rdata, 32'h12345678);
    check("midrst_recover_latency", 32'(lat), 32'd3);
    consume_rsp();

    check("valid_never_dropped", 32'(vld_drop), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
